// File: rtl/tod_slew_core.sv
// rtl/tod_slew_core.sv - time-of-day counter {sec, ns, sub_ns} with init load and step/slew offset
module tod_slew_core #(
   parameter int          TIME_WIDTH_SUB_NS = 20,
   parameter int          TIME_WIDTH_NS     = 32,
   parameter int          TIME_WIDTH_SEC    = 48,
   parameter int unsigned NS_PER_SEC        = 1000000000
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         set_init_time,
   input  logic [TIME_WIDTH_SUB_NS-1:0] init_time_sub_ns,
   input  logic [TIME_WIDTH_NS-1:0]     init_time_ns,
   input  logic [TIME_WIDTH_SEC-1:0]    init_time_sec,
   input  logic                         set_offset_time,
   input  logic                         plus_offset_time,
   input  logic                         offset_mode,
   input  logic [TIME_WIDTH_SUB_NS-1:0] offset_time_sub_ns,
   input  logic [TIME_WIDTH_NS-1:0]     offset_time_ns,
   input  logic [TIME_WIDTH_SUB_NS-1:0] incr_time_sub_ns,
   input  logic [TIME_WIDTH_NS-1:0]     incr_time_ns,
   input  logic [TIME_WIDTH_SUB_NS-1:0] slew_step_sub_ns,
   input  logic [TIME_WIDTH_NS-1:0]     slew_step_ns,
   output logic [TIME_WIDTH_SUB_NS-1:0] tod_sub_ns,
   output logic [TIME_WIDTH_NS-1:0]     tod_ns,
   output logic [TIME_WIDTH_SEC-1:0]    tod_sec,
   output logic                         pps,
   output logic                         offset_busy,
   output logic                         offset_done
);

   localparam int FW = TIME_WIDTH_NS + TIME_WIDTH_SUB_NS;
   // Three guard bits: sum stays below 3 * 2^FW and above -2^FW, so the MSB is a clean sign.
   localparam int EW = FW + 3;
   localparam logic [EW-1:0] NPS_F = EW'(NS_PER_SEC) << TIME_WIDTH_SUB_NS;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SLEW = 1'b1;

   logic [0:0]    state;
   logic [FW-1:0] rem;
   logic          slew_plus;

   logic [FW-1:0] step_f;
   logic [FW-1:0] off_f;
   logic [FW-1:0] slew_amt;
   logic [EW-1:0] base_f;
   logic [EW-1:0] adj_mag;
   logic          adj_plus;
   logic [EW-1:0] sum_f;
   logic [FW-1:0] norm_f;
   logic          carry;
   logic          borrow;

   assign offset_busy = (state == SLEW);

   always_comb begin
      step_f   = {slew_step_ns, slew_step_sub_ns};
      off_f    = {offset_time_ns, offset_time_sub_ns};
      slew_amt = (step_f < rem) ? step_f : rem;
      base_f   = EW'({tod_ns, tod_sub_ns}) + EW'({incr_time_ns, incr_time_sub_ns});
      adj_mag  = '0;
      adj_plus = 1'b1;
      if (state == SLEW) begin
         adj_mag  = EW'(slew_amt);
         adj_plus = slew_plus;
      end else if (set_offset_time && !offset_mode) begin
         adj_mag  = EW'(off_f);
         adj_plus = plus_offset_time;
      end
      sum_f  = adj_plus ? (base_f + adj_mag) : (base_f - adj_mag);
      carry  = 1'b0;
      borrow = 1'b0;
      norm_f = FW'(sum_f);
      if (sum_f[EW-1]) begin
         borrow = 1'b1;
         norm_f = FW'(sum_f + NPS_F);
      end else if (sum_f >= NPS_F) begin
         carry  = 1'b1;
         norm_f = FW'(sum_f - NPS_F);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tod_sub_ns  <= '0;
         tod_ns      <= '0;
         tod_sec     <= '0;
         pps         <= 1'b0;
         offset_done <= 1'b0;
         state       <= IDLE;
         rem         <= '0;
         slew_plus   <= 1'b0;
      end else begin
         pps         <= 1'b0;
         offset_done <= 1'b0;
         if (set_init_time) begin
            tod_sub_ns <= init_time_sub_ns;
            tod_ns     <= init_time_ns;
            tod_sec    <= init_time_sec;
            state      <= IDLE;
            rem        <= '0;
         end else begin
            tod_ns     <= norm_f[FW-1:TIME_WIDTH_SUB_NS];
            tod_sub_ns <= norm_f[TIME_WIDTH_SUB_NS-1:0];
            if (carry) begin
               tod_sec <= tod_sec + TIME_WIDTH_SEC'(1);
               pps     <= 1'b1;
            end else if (borrow) begin
               tod_sec <= tod_sec - TIME_WIDTH_SEC'(1);
            end
            // A strobe arriving mid-slew falls through here untouched.
            if (state == SLEW) begin
               rem <= rem - slew_amt;
               if (rem == slew_amt) begin
                  state       <= IDLE;
                  offset_done <= 1'b1;
               end
            end else if (set_offset_time) begin
               if (offset_mode) begin
                  state     <= SLEW;
                  rem       <= off_f;
                  slew_plus <= plus_offset_time;
               end else begin
                  offset_done <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_tod_slew_core.sv
// tb/tb_tod_slew_core.sv - bench for tod_slew_core against a total-time reference model
module tb_tod_slew_core;

   localparam int    SUB  = 20;
   localparam int    NSW  = 32;
   localparam int    SECW = 48;
   localparam longint NPS = 1000000000;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            set_init_time;
   logic [SUB-1:0]  init_time_sub_ns;
   logic [NSW-1:0]  init_time_ns;
   logic [SECW-1:0] init_time_sec;
   logic            set_offset_time;
   logic            plus_offset_time;
   logic            offset_mode;
   logic [SUB-1:0]  offset_time_sub_ns;
   logic [NSW-1:0]  offset_time_ns;
   logic [SUB-1:0]  incr_time_sub_ns;
   logic [NSW-1:0]  incr_time_ns;
   logic [SUB-1:0]  slew_step_sub_ns;
   logic [NSW-1:0]  slew_step_ns;
   logic [SUB-1:0]  tod_sub_ns;
   logic [NSW-1:0]  tod_ns;
   logic [SECW-1:0] tod_sec;
   logic            pps;
   logic            offset_busy;
   logic            offset_done;

   always #5 clk = ~clk;

   tod_slew_core dut (
      .clk(clk), .rst_n(rst_n),
      .set_init_time(set_init_time), .init_time_sub_ns(init_time_sub_ns),
      .init_time_ns(init_time_ns), .init_time_sec(init_time_sec),
      .set_offset_time(set_offset_time), .plus_offset_time(plus_offset_time),
      .offset_mode(offset_mode), .offset_time_sub_ns(offset_time_sub_ns),
      .offset_time_ns(offset_time_ns), .incr_time_sub_ns(incr_time_sub_ns),
      .incr_time_ns(incr_time_ns), .slew_step_sub_ns(slew_step_sub_ns),
      .slew_step_ns(slew_step_ns), .tod_sub_ns(tod_sub_ns), .tod_ns(tod_ns),
      .tod_sec(tod_sec), .pps(pps), .offset_busy(offset_busy), .offset_done(offset_done)
   );

   int checks = 0;
   int errors = 0;

   // Reference: time is one integer count of sub-ns units modulo 2^SECW seconds.
   logic [127:0] unit_s;
   logic [127:0] mod_t;
   logic [127:0] m_total;
   bit           m_busy, m_plus, m_pps, m_done;
   longint       m_rem;

   function automatic longint fx(input longint ns, input longint sub);
      return (ns <<< SUB) + sub;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [127:0] s, f;
      s = m_total / unit_s;
      f = m_total % unit_s;
      chk({tag, ".sec"}, 64'(tod_sec), 64'(s));
      chk({tag, ".ns"}, 64'(tod_ns), 64'(f >> SUB));
      chk({tag, ".sub"}, 64'(tod_sub_ns), 64'(f[SUB-1:0]));
      chk({tag, ".pps"}, 64'(pps), 64'(m_pps));
      chk({tag, ".busy"}, 64'(offset_busy), 64'(m_busy));
      chk({tag, ".done"}, 64'(offset_done), 64'(m_done));
   endtask

   task automatic model_reset();
      m_total = '0; m_busy = 0; m_plus = 0; m_pps = 0; m_done = 0; m_rem = 0;
   endtask

   task automatic model_step();
      longint delta, m, incr_f, off_f, step_f;
      logic [127:0] old_sec;
      incr_f = fx(longint'(incr_time_ns), longint'(incr_time_sub_ns));
      off_f  = fx(longint'(offset_time_ns), longint'(offset_time_sub_ns));
      step_f = fx(longint'(slew_step_ns), longint'(slew_step_sub_ns));
      m_done = 0;
      m_pps  = 0;
      if (set_init_time) begin
         m_total = 128'(init_time_sec) * unit_s + 128'(fx(longint'(init_time_ns), longint'(init_time_sub_ns)));
         m_busy = 0;
         m_rem  = 0;
         return;
      end
      delta = incr_f;
      if (m_busy) begin
         m = (step_f < m_rem) ? step_f : m_rem;
         delta = m_plus ? delta + m : delta - m;
         m_rem -= m;
         if (m_rem == 0) begin
            m_busy = 0;
            m_done = 1;
         end
      end else if (set_offset_time) begin
         if (offset_mode) begin
            m_busy = 1; m_rem = off_f; m_plus = plus_offset_time;
         end else begin
            delta = plus_offset_time ? delta + off_f : delta - off_f;
            m_done = 1;
         end
      end
      old_sec = m_total / unit_s;
      if (delta >= 0) m_total = (m_total + 128'(delta)) % mod_t;
      else m_total = (m_total + mod_t - 128'(-delta)) % mod_t;
      m_pps = (delta > 0) && ((m_total / unit_s) != old_sec);
   endtask

   task automatic tick(input string tag);
      model_step();
      @(posedge clk);
      #1;
      check_all(tag);
      set_init_time   = 0;
      set_offset_time = 0;
   endtask

   task automatic load(input longint sec, input longint ns);
      init_time_sec = SECW'(sec); init_time_ns = NSW'(ns); init_time_sub_ns = '0;
      set_init_time = 1;
   endtask

   task automatic offset(input bit plus, input bit mode, input longint ns);
      plus_offset_time = plus; offset_mode = mode;
      offset_time_ns = NSW'(ns); offset_time_sub_ns = '0;
      set_offset_time = 1;
   endtask

   initial begin
      int n, busy_cycles;
      logic [NSW-1:0] t0;
      unit_s = 128'(NPS) << SUB;
      mod_t  = (128'(1) << SECW) * unit_s;
      rst_n = 0;
      set_init_time = 0; init_time_sub_ns = '0; init_time_ns = '0; init_time_sec = '0;
      set_offset_time = 0; plus_offset_time = 0; offset_mode = 0;
      offset_time_sub_ns = '0; offset_time_ns = '0;
      incr_time_ns = 8; incr_time_sub_ns = '0;
      slew_step_ns = 2; slew_step_sub_ns = '0;
      model_reset();
      #1;
      check_all("reset");
      @(posedge clk); #1;
      rst_n = 1;
      check_all("reset_rel");

      for (int i = 0; i < 3; i++) tick("count8");
      chk("count8_ns24", 64'(tod_ns), 64'd24);

      load(5, 999_999_992);
      tick("init");
      tick("carry");
      chk("carry_sec6", 64'(tod_sec), 64'd6);
      chk("carry_pps", 64'(pps), 64'd1);
      tick("after_carry");
      chk("after_carry_ns8", 64'(tod_ns), 64'd8);

      load(6, 4);
      tick("init64");
      offset(0, 0, 20);
      tick("step_sub");
      chk("step_sub_sec5", 64'(tod_sec), 64'd5);
      chk("step_sub_ns", 64'(tod_ns), 64'd999_999_992);
      chk("step_sub_done", 64'(offset_done), 64'd1);
      tick("step_sub_after");

      load(7, 1000);
      tick("init_slew2");
      slew_step_ns = 2;
      offset(1, 1, 10);
      tick("slew2_strobe");
      t0 = tod_ns; n = 0; busy_cycles = 0;
      while (!offset_done && n < 20) begin
         if (offset_busy) busy_cycles++;
         tick("slew2");
         n++;
      end
      chk("slew2_busy_cycles", 64'(busy_cycles), 64'd5);
      chk("slew2_adj_cycles", 64'(n), 64'd5);
      chk("slew2_extra", 64'(tod_ns - t0), 64'd50);
      tick("slew2_after");

      slew_step_ns = 3;
      offset(1, 1, 10);
      tick("slew3_strobe");
      t0 = tod_ns; n = 0;
      while (!offset_done && n < 20) begin
         if (n == 1) offset(1, 0, 100);
         tick("slew3");
         n++;
      end
      chk("slew3_adj_cycles", 64'(n), 64'd4);
      chk("slew3_extra", 64'(tod_ns - t0), 64'd42);

      slew_step_ns = 1;
      offset(1, 1, 100);
      tick("abort_strobe");
      tick("abort_slew");
      tick("abort_slew");
      load(9, 500);
      tick("abort_init");
      chk("abort_ns", 64'(tod_ns), 64'd500);
      chk("abort_busy", 64'(offset_busy), 64'd0);
      tick("abort_after");
      chk("abort_plain", 64'(tod_ns), 64'd508);

      load((longint'(1) << SECW) - 1, 999_999_996);
      tick("wrap_init");
      tick("wrap");
      chk("wrap_sec0", 64'(tod_sec), 64'd0);

      offset(1, 1, 50);
      tick("rst_strobe");
      tick("rst_slew");
      rst_n = 0;
      model_reset();
      #1;
      check_all("rst_mid");
      @(posedge clk); #1;
      rst_n = 1;

      for (int i = 0; i < 400; i++) begin
         int r;
         r = int'($urandom_range(0, 99));
         incr_time_ns = NSW'($urandom_range(16, 300));
         incr_time_sub_ns = SUB'($urandom);
         slew_step_ns = NSW'($urandom_range(0, int'(incr_time_ns) - 1));
         slew_step_sub_ns = SUB'($urandom) | SUB'(1);
         if (r < 3) begin
            init_time_sec = (r == 0) ? {SECW{1'b1}} : SECW'($urandom);
            init_time_ns = NSW'($urandom_range(999_990_000, 999_999_999));
            init_time_sub_ns = SUB'($urandom);
            set_init_time = 1;
         end else if (r < 20) begin
            plus_offset_time = $urandom_range(0, 1) != 0;
            offset_mode = $urandom_range(0, 1) != 0;
            offset_time_ns = NSW'($urandom_range(0, 3000));
            offset_time_sub_ns = SUB'($urandom);
            set_offset_time = 1;
         end
         tick("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tod_slew_core.md
# tod_slew_core

Parametrised time-of-day counter that keeps {seconds, nanoseconds, sub-nanoseconds} time.
- Advances by a programmable per-cycle increment.
- Accepts an initial-time load.
- Applies a signed offset either as an immediate step or as a gradual slew, with busy/done handshake and a PPS pulse.
- Replaces the fixed-width, step-only ToD core as the timebase feeding timestamping logic.

## Interface
- TIME_WIDTH_SUB_NS, 20, fractional-ns bits (1 LSB = 2^-20 ns)
- TIME_WIDTH_NS, 32, ns field width
- TIME_WIDTH_SEC, 48, seconds field width; wraps modulo 2^TIME_WIDTH_SEC
- NS_PER_SEC, 1000000000, ns rollover value; overridable for simulation
- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- set_init_time  in  1  load init_time_* (one-cycle strobe)
- init_time_sub_ns / init_time_ns / init_time_sec  in  SUB_NS / NS / SEC  load value
- set_offset_time  in  1  offset command strobe
- plus_offset_time  in  1  1 = add offset, 0 = subtract
- offset_mode  in  1  0 = step, 1 = slew
- offset_time_sub_ns / offset_time_ns  in  SUB_NS / NS  offset magnitude, ns < NS_PER_SEC
- incr_time_sub_ns / incr_time_ns  in  SUB_NS / NS  per-cycle increment, ns < NS_PER_SEC
- slew_step_sub_ns / slew_step_ns  in  SUB_NS / NS  max per-cycle slew correction
- tod_sub_ns / tod_ns / tod_sec  out  SUB_NS / NS / SEC  current time, registered
- pps  out  1  one-cycle pulse when seconds carry
- offset_busy  out  1  slew in progress
- offset_done  out  1  one-cycle pulse on offset completion

## Operation
- Arithmetic is on the fixed-point value F = {ns, sub_ns}. After the add, if ns >= NS_PER_SEC: subtract NS_PER_SEC and increment sec. If the result is negative: add NS_PER_SEC and decrement sec. One carry or borrow at most per cycle.
- Normal cycle: F += incr + adj, where adj is signed and is 0 outside slew.
- Priority at each edge: set_init_time > set_offset_time > normal increment.
- set_init_time: tod <= init exactly, with no increment that cycle. It aborts any slew: offset_busy <= 0, remainder cleared, no offset_done.
- Step mode (offset_mode=0): tod <= tod + incr ± offset in one cycle. offset_done pulses the next cycle. offset_busy stays 0.
- Slew mode (offset_mode=1): latch remaining R = offset magnitude and the sign. FSM moves IDLE -> SLEW.
  - Each SLEW cycle: adj = ±min(slew_step, R) and R -= min(slew_step, R).
  - When R reaches 0 after an update: SLEW -> IDLE, offset_done pulses one cycle.
  - Slew with offset 0: a single SLEW cycle with adj 0, then done.
- set_offset_time while offset_busy=1 is ignored: no state change, no done.
- Input constraint for subtract slew: slew_step < incr, which keeps time monotonic. The block does not check it.
- pps asserts only on a carry from the increment/slew/step-add path. A borrow or a set_init_time never asserts pps.
- tod_sec wraps from 2^TIME_WIDTH_SEC-1 to 0 on carry, with pps.

## Timing
- Reset values: tod_* = 0, pps = 0, offset_busy = 0, offset_done = 0, FSM = IDLE, R = 0.
- All outputs are registered. Every event takes effect at the sampling edge and is visible in the following cycle.
- pps is high in the same cycle tod_sec first shows the incremented value.
- offset_busy rises in the cycle after a slew strobe is sampled. It falls in the same cycle offset_done is high.
- Step offset_done: high in the cycle after the strobe edge, while tod already shows the stepped value.
- Slew latency: ceil(offset/slew_step) adjustment cycles, minimum 1.
- Reset mid-slew clears everything immediately, asynchronously.

## Test plan
- Reset, then incr = 8 ns, sub 0, for 3 cycles -> tod_ns = 0, 8, 16, 24. tod_sec = 0, pps = 0, offset_busy = 0 throughout.
- set_init_time with ns = 999_999_992, sec = 5, and incr 8 ns -> tod (5, 999_999_992), then (6, 0) with pps = 1 for exactly that cycle, then (6, 8) with pps = 0.
- At tod (6, 4): step subtract of 20 ns with incr 8 -> tod (5, 999_999_992), pps = 0, offset_done = 1 for one cycle.
- Slew add of 10 ns with slew_step 2 ns and incr 8 ns -> offset_busy high for 5 cycles, tod_ns advancing 10 per cycle, offset_done on the 5th cycle. After that, the advance is 8 per cycle and the total extra is exactly 10 ns.
- Slew add 10 ns / step 3 ns -> adjustments 3, 3, 3, 1. A second set_offset_time strobe during busy is ignored.
- set_init_time mid-slew -> tod = init exactly, offset_busy = 0 next cycle, no offset_done, subsequent increments are plain incr.
